// File: rtl/nano_ifetch.sv
// Instruction fetch stage: one outstanding imem read, small PC-tagged instruction
// buffer toward decode, and redirect handling that drops responses from flushed streams.
module nano_ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]       state;
    logic [31:0]      fetch_pc;
    logic [31:0]      fifo_inst [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             issue;
    logic             push;
    logic             pop;
    logic             busy_next;

    always_comb begin
        o_imem_req   = !i_rst && (state == ST_REQ) && (count < FULL_CNT);
        o_imem_addr  = i_rst ? RESET_PC : fetch_pc;
        issue        = o_imem_req && i_imem_gnt;
        push         = !i_redirect && (state == ST_WAIT) && i_imem_rvalid;
        o_inst_valid = !i_rst && (count != '0);
        pop          = o_inst_valid && i_inst_ready;
        o_inst       = o_inst_valid ? fifo_inst[rd_ptr] : 32'h0000_0013;
        o_inst_pc    = o_inst_valid ? fifo_pc[rd_ptr]   : 32'h0000_0000;
        // A request is still in flight after this cycle if one was waiting and no
        // response came back, or if a new one is being issued right now.
        if (state == ST_WAIT || state == ST_DROP)
            busy_next = !i_imem_rvalid;
        else
            busy_next = issue;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_REQ;
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (i_redirect) begin
            state    <= busy_next ? ST_DROP : ST_REQ;
            fetch_pc <= i_redirect_pc & ~32'd3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (issue) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: if (i_imem_rvalid) state <= ST_REQ;
                ST_DROP: if (i_imem_rvalid) state <= ST_REQ;
                default: state <= ST_REQ;
            endcase
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= i_imem_rdata;
            fifo_pc[wr_ptr]   <= fetch_pc - 32'd4;
        end
    end
endmodule

// File: tb/tb_nano_ifetch.sv
// Bench for nano_ifetch: memory model plus stream-level reference (epochs, PC sequence)
// feeding a scoreboard that is checked every cycle on the falling edge.
module tb_nano_ifetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready = 1'b0;

    nano_ifetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
        .i_inst_ready(i_inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned rgen;
        int unsigned due;
    } pend_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    pend_t       pend[$];
    exp_t        exp_q[$];
    int unsigned cyc = 0, epoch = 0, rgen = 0, delivered = 0;
    logic [31:0] exp_pc = RESET_PC;
    int          checks = 0, errors = 0;
    int          gnt_mode = 1, ready_mode = 1, lat_min = 0, lat_max = 0;
    int          redir_rate = 0, spur_rate = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1234_5678;
    endfunction

    function automatic int unsigned live_out();
        int unsigned n = 0;
        foreach (pend[i]) if (pend[i].rgen == rgen) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard/monitor: compares at the falling edge, then advances the model
    // with the events that the coming rising edge will commit.
    always @(negedge clk) begin : monitor
        pend_t p;
        exp_t  e;
        logic  exp_req;
        if (i_rst) begin
            chk("rst_req", 32'(o_imem_req), 32'd0);
            chk("rst_addr", o_imem_addr, RESET_PC);
            chk("rst_valid", 32'(o_inst_valid), 32'd0);
            if (i_imem_rvalid && pend.size() != 0) void'(pend.pop_front());
            exp_q.delete();
            exp_pc = RESET_PC;
            epoch++;
            rgen++;
        end else begin
            exp_req = (live_out() == 0) && (exp_q.size() < DEPTH);
            chk("imem_req", 32'(o_imem_req), 32'(exp_req));
            if (o_imem_req) chk("imem_addr", o_imem_addr, exp_pc);
            chk("inst_valid", 32'(o_inst_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("inst", o_inst, exp_q[0].inst);
                chk("inst_pc", o_inst_pc, exp_q[0].pc);
                if (i_inst_ready) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
            end else begin
                chk("idle_inst", o_inst, 32'h0000_0013);
                chk("idle_pc", o_inst_pc, 32'h0);
            end
            if (i_imem_rvalid && pend.size() != 0) begin
                p = pend.pop_front();
                if (p.rgen == rgen && p.epoch == epoch && !i_redirect) begin
                    e.pc   = p.addr;
                    e.inst = memf(p.addr);
                    exp_q.push_back(e);
                end
            end
            if (exp_req && i_imem_gnt) begin
                p.addr  = exp_pc;
                p.epoch = epoch;
                p.rgen  = rgen;
                p.due   = cyc + 1 + $urandom_range(lat_min, lat_max);
                pend.push_back(p);
                exp_pc = exp_pc + 32'd4;
            end
            if (i_redirect) begin
                exp_q.delete();
                epoch++;
                exp_pc = i_redirect_pc & ~32'd3;
            end
        end
    end

    // One clock of stimulus: memory responses, grants, ready and random redirects.
    task automatic step();
        logic stale;
        @(posedge clk);
        cyc++;
        #1;
        stale = 1'b0;
        foreach (pend[i]) if (pend[i].rgen != rgen) stale = 1'b1;
        i_imem_gnt = stale ? 1'b0 : (gnt_mode == 2 ? ($urandom_range(0, 1) == 1) : (gnt_mode == 1));
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = memf(pend[0].addr);
        end else if (pend.size() == 0 && spur_rate != 0 && $urandom_range(0, spur_rate - 1) == 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = $urandom;
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = $urandom;
        end
        i_inst_ready = ready_mode == 2 ? ($urandom_range(0, 1) == 1) : (ready_mode == 1);
        if (redir_rate != 0 && !i_rst && $urandom_range(0, redir_rate - 1) == 0) begin
            i_redirect    = 1'b1;
            i_redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
        end else begin
            i_redirect    = 1'b0;
            i_redirect_pc = $urandom;
        end
    endtask

    task automatic redirect_now(input logic [31:0] tgt);
        i_redirect    = 1'b1;
        i_redirect_pc = tgt;
    endtask

    task automatic wait_live(input int budget);
        for (int i = 0; i < budget && live_out() == 0; i++) step();
        chk("wait_outstanding", 32'(live_out() != 0), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && pend.size() != 0; i++) step();
        chk("wait_idle", 32'(pend.size()), 32'd0);
    endtask

    initial begin
        int unsigned d0;
        // Reset, then streaming with gnt=1, 1-cycle latency, ready=1
        repeat (3) step();
        i_rst = 1'b0;
        repeat (12) step();
        chk("t1_progress", 32'(delivered >= 3), 32'd1);
        // Decode stalled: buffer fills to DEPTH, then drains in order
        ready_mode = 0;
        repeat (10) step();
        ready_mode = 1;
        repeat (10) step();
        // Redirect while a request is outstanding
        lat_min = 2; lat_max = 3;
        wait_live(20);
        redirect_now(32'h0000_0103);
        repeat (15) step();
        lat_min = 0; lat_max = 0;
        // Grant withheld; redirect during the stall
        gnt_mode = 0;
        wait_idle(20);
        step(); step(); step();
        redirect_now(32'h0000_0200);
        step(); step();
        gnt_mode = 1;
        repeat (10) step();
        // Address wrap
        redirect_now(32'hFFFF_FFFC);
        repeat (10) step();
        // Reset while waiting; stale response arrives after release
        lat_min = 4; lat_max = 4;
        wait_live(20);
        i_rst = 1'b1;
        step(); step();
        i_rst = 1'b0;
        lat_min = 0; lat_max = 0;
        repeat (15) step();
        chk("t6_progress", 32'(delivered >= 10), 32'd1);
        // Randomized traffic
        d0 = delivered;
        gnt_mode = 2; ready_mode = 2; lat_max = 3; redir_rate = 25; spur_rate = 8;
        repeat (3000) step();
        chk("rand_progress", 32'(delivered > d0 + 100), 32'd1);
        redir_rate = 0; spur_rate = 0;
        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
